// File: rtl/alu_instr_encoder_if.sv
// ---------------------------------------------------------------------------
// alu_instr_encoder_if
// Purpose : groups the request stream (ALU op + operands in) and the
//           instruction stream (encoded RV32I word out) of the ALU
//           instruction encoder.
// Signals :
//   req_valid / req_ready        request handshake
//   req_aluctl[2:0]              ALUControl op code
//   req_itype                    1 = I-type (immediate form), 0 = R-type
//   req_rd/req_rs1/req_rs2[4:0]  register operands
//   req_imm[11:0]                immediate operand
//   instr_valid / instr_ready    instruction handshake
//   instr[31:0]                  encoded instruction word (FIFO head)
// Modports:
//   master : request producer / instruction consumer (core side, bench)
//   slave  : the encoder itself
// ---------------------------------------------------------------------------
interface alu_instr_encoder_if;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_aluctl;
    logic        req_itype;
    logic [4:0]  req_rd;
    logic [4:0]  req_rs1;
    logic [4:0]  req_rs2;
    logic [11:0] req_imm;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;

    modport master (
        output req_valid, req_aluctl, req_itype, req_rd, req_rs1, req_rs2, req_imm,
        input  req_ready,
        input  instr_valid, instr,
        output instr_ready
    );

    modport slave (
        input  req_valid, req_aluctl, req_itype, req_rd, req_rs1, req_rs2, req_imm,
        output req_ready,
        output instr_valid, instr,
        input  instr_ready
    );
endinterface

// File: rtl/alu_instr_encoder.sv
// ---------------------------------------------------------------------------
// alu_instr_encoder
// Purpose : converse of the ALU control decoder. Encodes an ALUControl op
//           plus register/immediate operands into a 32-bit RV32I R-type or
//           I-type instruction word, buffers the words in a DEPTH-entry FIFO
//           and drains them over a valid/ready stream.
// Ports   :
//   clk      in   clock, all state on rising edge
//   reset    in   asynchronous active-high reset, clears all state
//   bus      slave modport of alu_instr_encoder_if (request + instr streams)
//   level    out  FIFO occupancy, 0..DEPTH
//   err      out  sticky flag: an illegal request was dropped
//   err_cnt  out  saturating count of dropped requests
//   err_clr  in   synchronous clear of err/err_cnt (wins over a same-cycle drop)
// Parameters:
//   DEPTH  FIFO entries, power of two, >= 2
//   ERRW   width of the illegal-request counter
// Configuration macro:
//   ALUENC_SHIFT_EN  when defined, aluctl 110/111 encode sll/srl (slli/srli
//                    in I-type form, shamt = imm[4:0], imm[11:5] forced 0).
//                    When undefined, 110/111 are illegal and dropped.
// ---------------------------------------------------------------------------
module alu_instr_encoder #(
    parameter int DEPTH = 4,
    parameter int ERRW  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    alu_instr_encoder_if.slave       bus,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     err,
    output logic [ERRW-1:0]          err_cnt,
    input  logic                     err_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ZERO = (AW+1)'(0);
    localparam logic [ERRW-1:0] ERR_ONE = ERRW'(1);

    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;

    // Returns {legal, word}. legal=0 marks a request that must be dropped.
    function automatic logic [32:0] encode(
        input logic [2:0]  aluctl,
        input logic        itype,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [11:0] imm
    );
        logic        legal;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [6:0]  opcode;
        logic [11:0] imm_eff;
        logic [31:0] word;
        legal   = 1'b1;
        funct3  = 3'b000;
        funct7  = 7'b0000000;
        imm_eff = imm;
        opcode  = itype ? OP_ITYPE : OP_RTYPE;
        case (aluctl)
            3'b000: funct3 = 3'b000;
            3'b001: begin
                funct3 = 3'b000;
                funct7 = 7'b0100000;
                // RV32I has no subi
                if (itype) begin
                    legal = 1'b0;
                end else begin
                    legal = 1'b1;
                end
            end
            3'b010: funct3 = 3'b111;
            3'b011: funct3 = 3'b110;
            3'b100: funct3 = 3'b100;
            3'b101: funct3 = 3'b010;
`ifdef ALUENC_SHIFT_EN
            3'b110: begin
                funct3  = 3'b001;
                imm_eff = {7'b0000000, imm[4:0]};
            end
            3'b111: begin
                funct3  = 3'b101;
                imm_eff = {7'b0000000, imm[4:0]};
            end
`endif
            default: begin
                funct3 = 3'b000;
                legal  = 1'b0;
            end
        endcase
        if (itype) begin
            word = {imm_eff, rs1, funct3, rd, opcode};
        end else begin
            word = {funct7, rs2, rs1, funct3, rd, opcode};
        end
        return {legal, word};
    endfunction

    logic [31:0]   mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic          err_r;
    logic [ERRW-1:0] err_cnt_r;

    logic        full_s;
    logic        empty_s;
    logic        accept_s;
    logic        legal_s;
    logic [31:0] word_s;
    logic        push_s;
    logic        pop_s;
    logic        drop_s;

    // Handshake decode and encoding of the presented request.
    always_comb begin
        full_s   = (count_r == CNT_FULL);
        empty_s  = (count_r == CNT_ZERO);
        {legal_s, word_s} = encode(bus.req_aluctl, bus.req_itype, bus.req_rd,
                                   bus.req_rs1, bus.req_rs2, bus.req_imm);
        // Acceptance depends only on fullness: no pass-through on a same-cycle pop.
        accept_s = bus.req_valid & ~full_s;
        push_s   = accept_s & legal_s;
        drop_s   = accept_s & ~legal_s;
        pop_s    = ~empty_s & bus.instr_ready;
    end

    // FIFO storage, pointers and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 32'h0000_0000;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= CNT_ZERO;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= word_s;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Sticky error flag and saturating drop counter; clear beats a same-cycle drop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_r     <= 1'b0;
            err_cnt_r <= '0;
        end else if (err_clr) begin
            err_r     <= 1'b0;
            err_cnt_r <= '0;
        end else if (drop_s) begin
            err_r <= 1'b1;
            if (err_cnt_r != {ERRW{1'b1}}) begin
                err_cnt_r <= err_cnt_r + ERR_ONE;
            end
        end
    end

    // Head is read straight out of storage, so it holds until popped.
    assign bus.instr       = mem_r[rd_ptr_r];
    assign bus.instr_valid = ~empty_s;
    assign bus.req_ready   = ~full_s;
    assign level           = count_r;
    assign err             = err_r;
    assign err_cnt         = err_cnt_r;

endmodule

// File: tb/tb_alu_instr_encoder.sv
module tb_alu_instr_encoder;

    localparam int DEPTH = 4;
    localparam int ERRW  = 3;
`ifdef ALUENC_SHIFT_EN
    localparam bit SHIFT_EN = 1'b1;
`else
    localparam bit SHIFT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic err_clr;
    logic [$clog2(DEPTH):0] level;
    logic err;
    logic [ERRW-1:0] err_cnt;

    alu_instr_encoder_if bus ();

    alu_instr_encoder #(.DEPTH(DEPTH), .ERRW(ERRW)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus.slave),
        .level   (level),
        .err     (err),
        .err_cnt (err_cnt),
        .err_clr (err_clr)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Reference state: queue of pending words plus error bookkeeping.
    logic [31:0] mq[$];
    bit          m_err;
    int          m_cnt;
    int          f3tab[8] = '{0, 0, 7, 6, 4, 2, 1, 5};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference encoder built from field positions with shifts and ORs.
    function automatic logic [32:0] model_enc(input logic [2:0] a, input logic it,
                                              input logic [4:0] rd, input logic [4:0] rs1,
                                              input logic [4:0] rs2, input logic [11:0] imm);
        logic [31:0] w;
        logic [11:0] iv;
        bit ok;
        ok = (int'(a) < 6) || SHIFT_EN;
        if (a == 3'd1 && it) ok = 1'b0;
        iv = (int'(a) >= 6) ? (imm & 12'h01F) : imm;
        w  = it ? 32'h0000_0013 : 32'h0000_0033;
        w  = w | (32'(rd) << 7) | (32'(f3tab[a]) << 12) | (32'(rs1) << 15);
        if (it) w = w | (32'(iv) << 20);
        else begin
            w = w | (32'(rs2) << 20);
            if (a == 3'd1) w = w | 32'h4000_0000;
        end
        return {ok, w};
    endfunction

    // Reference model steps on every edge using the inputs the DUT sees.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
            m_err = 1'b0;
            m_cnt = 0;
        end else begin
            logic [32:0] r;
            bit acc;
            bit pop;
            acc = bus.req_valid && (mq.size() < DEPTH);
            pop = (mq.size() > 0) && bus.instr_ready;
            r   = model_enc(bus.req_aluctl, bus.req_itype, bus.req_rd, bus.req_rs1,
                            bus.req_rs2, bus.req_imm);
            if (pop) void'(mq.pop_front());
            if (acc && r[32]) mq.push_back(r[31:0]);
            if (err_clr) begin
                m_err = 1'b0;
                m_cnt = 0;
            end else if (acc && !r[32]) begin
                m_err = 1'b1;
                if (m_cnt < (1 << ERRW) - 1) m_cnt++;
            end
        end
    end

    // Compare DUT outputs against the model mid-cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            check("instr_valid", 32'(bus.instr_valid), 32'(mq.size() > 0));
            check("level", 32'(level), 32'(mq.size()));
            check("req_ready", 32'(bus.req_ready), 32'(mq.size() < DEPTH));
            check("err", 32'(err), 32'(m_err));
            check("err_cnt", 32'(err_cnt), 32'(m_cnt));
            if (mq.size() > 0) check("instr", bus.instr, mq[0]);
        end
    end

    task automatic cycle();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input logic [2:0] a, input logic it, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [11:0] imm);
        bus.req_valid  = 1'b1;
        bus.req_aluctl = a;
        bus.req_itype  = it;
        bus.req_rd     = rd;
        bus.req_rs1    = rs1;
        bus.req_rs2    = rs2;
        bus.req_imm    = imm;
        cycle();
        bus.req_valid  = 1'b0;
    endtask

    initial begin
        logic [32:0] pin;
        reset           = 1'b1;
        err_clr         = 1'b0;
        bus.req_valid   = 1'b0;
        bus.req_aluctl  = 3'd0;
        bus.req_itype   = 1'b0;
        bus.req_rd      = 5'd0;
        bus.req_rs1     = 5'd0;
        bus.req_rs2     = 5'd0;
        bus.req_imm     = 12'd0;
        bus.instr_ready = 1'b0;
        cycle();
        cycle();
        reset = 1'b0;
        cycle();
        chk_en = 1'b1;

        // Model pins against hand-encoded words.
        pin = model_enc(3'd1, 1'b0, 5'd3, 5'd1, 5'd2, 12'd0);
        check("pin_sub", pin[31:0], 32'h402081B3);
        pin = model_enc(3'd0, 1'b1, 5'd5, 5'd0, 5'd0, 12'h7FF);
        check("pin_addi", pin[31:0], 32'h7FF00293);
        pin = model_enc(3'd5, 1'b1, 5'd1, 5'd2, 5'd0, 12'hFFF);
        check("pin_slti", pin[31:0], 32'hFFF12093);

        // Reset state, literal.
        check("rst_ready", 32'(bus.req_ready), 32'd1);
        check("rst_valid", 32'(bus.instr_valid), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_instr", bus.instr, 32'd0);

        // Spot encodings, one word at a time.
        push(3'd1, 1'b0, 5'd3, 5'd1, 5'd2, 12'd0);
        check("sub_instr", bus.instr, 32'h402081B3);
        check("sub_valid", 32'(bus.instr_valid), 32'd1);
        check("sub_level", 32'(level), 32'd1);
        bus.instr_ready = 1'b1;
        cycle();
        bus.instr_ready = 1'b0;
        push(3'd0, 1'b1, 5'd5, 5'd0, 5'd0, 12'h7FF);
        check("addi_instr", bus.instr, 32'h7FF00293);
        bus.instr_ready = 1'b1;
        cycle();
        bus.instr_ready = 1'b0;
        push(3'd5, 1'b1, 5'd1, 5'd2, 5'd0, 12'hFFF);
        check("slti_instr", bus.instr, 32'hFFF12093);
        bus.instr_ready = 1'b1;
        cycle();
        bus.instr_ready = 1'b0;

        // Fill to DEPTH, try one more, then drain in order.
        for (int i = 0; i < DEPTH; i++)
            push(3'(i % 6), 1'b0, 5'(i + 1), 5'(i + 2), 5'(i + 3), 12'd0);
        check("full_ready", 32'(bus.req_ready), 32'd0);
        check("full_level", 32'(level), 32'(DEPTH));
        push(3'd0, 1'b0, 5'd9, 5'd9, 5'd9, 12'd0);
        check("full_nopush", 32'(level), 32'(DEPTH));
        check("full_noerr", 32'(err), 32'd0);
        bus.instr_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) cycle();
        check("drained", 32'(level), 32'd0);
        bus.instr_ready = 1'b0;

        // Illegal requests are dropped and counted.
`ifndef ALUENC_SHIFT_EN
        push(3'b110, 1'b0, 5'd1, 5'd1, 5'd1, 12'd0);
`else
        push(3'b001, 1'b1, 5'd1, 5'd1, 5'd0, 12'd4);
`endif
        push(3'b001, 1'b1, 5'd2, 5'd2, 5'd0, 12'd1);
        check("ill_level", 32'(level), 32'd0);
        check("ill_err", 32'(err), 32'd1);
        check("ill_cnt", 32'(err_cnt), 32'd2);
        for (int i = 0; i < 8; i++) push(3'b001, 1'b1, 5'd2, 5'd2, 5'd0, 12'd1);
        check("sat_cnt", 32'(err_cnt), 32'd7);
        err_clr = 1'b1;
        push(3'b001, 1'b1, 5'd2, 5'd2, 5'd0, 12'd1);
        err_clr = 1'b0;
        check("clr_err", 32'(err), 32'd0);
        check("clr_cnt", 32'(err_cnt), 32'd0);

`ifdef ALUENC_SHIFT_EN
        push(3'b110, 1'b1, 5'd1, 5'd1, 5'd0, 12'hFE3);
        check("slli_instr", bus.instr, 32'h00309093);
        bus.instr_ready = 1'b1;
        cycle();
        bus.instr_ready = 1'b0;
`endif

        // Randomised traffic with occasional clears and mid-stream resets.
        for (int n = 0; n < 3000; n++) begin
            bus.req_valid   = ($urandom_range(0, 2) != 0);
            bus.req_aluctl  = 3'($urandom_range(0, 7));
            bus.req_itype   = 1'($urandom_range(0, 1));
            bus.req_rd      = 5'($urandom);
            bus.req_rs1     = 5'($urandom);
            bus.req_rs2     = 5'($urandom);
            bus.req_imm     = 12'($urandom);
            bus.instr_ready = ($urandom_range(0, 2) == 0);
            err_clr         = ($urandom_range(0, 40) == 0);
            if ($urandom_range(0, 400) == 0) begin
                reset = 1'b1;
                cycle();
                reset = 1'b0;
            end
            cycle();
        end
        bus.req_valid = 1'b0;
        err_clr       = 1'b0;
        cycle();
        chk_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
